// File: rtl/timer_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl_gen
// Purpose  : Control FSM for a countdown timer with NUM_FIELDS editable
//            fields. It sequences IDLE/RUN/SET/END. It also provides a
//            wrap-around or saturating cursor, hold-to-auto-repeat on Up/Down,
//            a cursor blink phase, start inhibit at zero and an alarm
//            auto-dismiss timeout.
// Ports    : iClk, iRst_n (async, active-low), iTick (timebase strobe),
//            iTimer (mode qualifier), iSet (set switch level),
//            iEnd (count reached zero pulse), iZero (count is zero level),
//            iBtn_U/D/L/R (press pulses), iHold_U/D (button levels)
//            -> oRun, oClear, oField_Up, oField_Down, oSel, oBlink, oEnd
//            (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl_gen #(
    parameter int NUM_FIELDS  = 3,
    parameter int WRAP        = 1,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_RATE = 100,
    parameter int BLINK_HALF  = 250,
    parameter int ALARM_TICKS = 10000
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  iTick,
    input  logic                  iTimer,
    input  logic                  iSet,
    input  logic                  iEnd,
    input  logic                  iZero,
    input  logic                  iBtn_U,
    input  logic                  iBtn_D,
    input  logic                  iBtn_L,
    input  logic                  iBtn_R,
    input  logic                  iHold_U,
    input  logic                  iHold_D,
    output logic                  oRun,
    output logic                  oClear,
    output logic [NUM_FIELDS-1:0] oField_Up,
    output logic [NUM_FIELDS-1:0] oField_Down,
    output logic [NUM_FIELDS-1:0] oSel,
    output logic                  oBlink,
    output logic                  oEnd
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_SET  = 2'd2;
    localparam logic [1:0] c_END  = 2'd3;

    localparam int CW = $clog2(NUM_FIELDS);
    localparam int HW = $clog2(REPEAT_DLY) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;
    localparam int AW = $clog2(ALARM_TICKS) + 1;

    localparam logic [CW-1:0] c_LAST      = CW'(NUM_FIELDS - 1);
    localparam logic [HW-1:0] c_REP_DLY   = HW'(REPEAT_DLY);
    // Reload so that the next strobe lands REPEAT_RATE ticks later.
    localparam logic [HW-1:0] c_REP_LOAD  = (REPEAT_RATE >= REPEAT_DLY) ? '0
                                            : HW'(REPEAT_DLY - REPEAT_RATE);
    localparam logic [BW-1:0] c_BLINK     = BW'(BLINK_HALF);
    localparam logic [AW-1:0] c_ALARM     = AW'(ALARM_TICKS);
    localparam logic [NUM_FIELDS-1:0] c_ONE = {{(NUM_FIELDS-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [CW-1:0] r_cursor;
    logic [HW-1:0] r_holdCnt;
    logic [BW-1:0] r_blinkCnt;
    logic          r_blinkPhase;
    logic [AW-1:0] r_alarmCnt;

    logic [1:0]    w_nextState;
    logic [CW-1:0] w_nextCursor;
    logic          w_clear;
    logic          w_move;
    logic          w_bU, w_bD, w_bL, w_bR;
    logic          w_inSet;
    logic          w_alarmDone;
    logic [AW-1:0] w_alarmInc;
    logic [AW-1:0] w_alarmCntNext;
    logic [HW-1:0] w_holdInc;
    logic [HW-1:0] w_holdCntNext;
    logic          w_repUp, w_repDn;
    logic          w_up, w_dn;
    logic [BW-1:0] w_blinkInc;
    logic [BW-1:0] w_blinkCntNext;
    logic          w_blinkPhaseNext;

    // Buttons only count while timer mode is selected.
    assign w_bU = iBtn_U & iTimer;
    assign w_bD = iBtn_D & iTimer;
    assign w_bL = iBtn_L & iTimer;
    assign w_bR = iBtn_R & iTimer;

    assign w_alarmInc  = r_alarmCnt + 1'b1;
    assign w_alarmDone = (ALARM_TICKS != 0) && (r_state == c_END) && iTick
                         && (w_alarmInc == c_ALARM);

    // ------------------------------------------------------------------
    // State and cursor
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState  = r_state;
        w_nextCursor = r_cursor;
        w_clear      = 1'b0;
        w_move       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (iSet && iTimer) begin
                    w_nextState  = c_SET;
                    w_nextCursor = '0;
                end else if (w_bL) begin
                    w_clear = 1'b1;
                end else if (w_bR && !iZero) begin
                    w_nextState = c_RUN;
                end
            end
            c_RUN: begin
                if (w_bR) begin
                    w_nextState = c_IDLE;
                end else if (iEnd) begin
                    w_nextState = c_END;
                end
            end
            c_SET: begin
                if (!iSet || !iTimer) begin
                    w_nextState = c_IDLE;
                end else if (w_bL && !w_bR) begin
                    if (r_cursor != c_LAST) begin
                        w_nextCursor = r_cursor + 1'b1;
                        w_move       = 1'b1;
                    end else if (WRAP != 0) begin
                        w_nextCursor = '0;
                        w_move       = 1'b1;
                    end
                end else if (w_bR && !w_bL) begin
                    if (r_cursor != '0) begin
                        w_nextCursor = r_cursor - 1'b1;
                        w_move       = 1'b1;
                    end else if (WRAP != 0) begin
                        w_nextCursor = c_LAST;
                        w_move       = 1'b1;
                    end
                end
            end
            c_END: begin
                if (w_bU || w_bD || w_bL || w_bR || w_alarmDone) begin
                    w_nextState = c_IDLE;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    // Editing activity only while staying in SET; leaving SET wins over buttons.
    assign w_inSet = (r_state == c_SET) && (w_nextState == c_SET);

    // ------------------------------------------------------------------
    // Auto-repeat hold counter and Up/Down strobes
    // ------------------------------------------------------------------
    assign w_holdInc = r_holdCnt + 1'b1;

    always_comb begin
        w_holdCntNext = r_holdCnt;
        w_repUp       = 1'b0;
        w_repDn       = 1'b0;
        if (!w_inSet || w_bU || w_bD || !(iHold_U ^ iHold_D) || w_move) begin
            w_holdCntNext = '0;
        end else if (iTick) begin
            if (w_holdInc == c_REP_DLY) begin
                w_holdCntNext = c_REP_LOAD;
                w_repUp       = iHold_U;
                w_repDn       = iHold_D;
            end else begin
                w_holdCntNext = w_holdInc;
            end
        end
    end

    assign w_up = w_inSet && ((w_bU && !w_bD) || w_repUp);
    assign w_dn = w_inSet && ((w_bD && !w_bU) || w_repDn);

    // ------------------------------------------------------------------
    // Blink phase
    // ------------------------------------------------------------------
    assign w_blinkInc = r_blinkCnt + 1'b1;

    always_comb begin
        w_blinkCntNext   = r_blinkCnt;
        w_blinkPhaseNext = r_blinkPhase;
        if (!w_inSet || w_move || w_up || w_dn) begin
            // Edits force the field visible so the user sees the change.
            w_blinkCntNext   = '0;
            w_blinkPhaseNext = 1'b1;
        end else if (iTick) begin
            if (w_blinkInc >= c_BLINK) begin
                w_blinkCntNext   = '0;
                w_blinkPhaseNext = ~r_blinkPhase;
            end else begin
                w_blinkCntNext = w_blinkInc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Alarm counter: counts only while remaining in END
    // ------------------------------------------------------------------
    always_comb begin
        w_alarmCntNext = '0;
        if ((r_state == c_END) && (w_nextState == c_END)) begin
            w_alarmCntNext = iTick ? w_alarmInc : r_alarmCnt;
        end
    end

    // ------------------------------------------------------------------
    // Registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state      <= c_IDLE;
            r_cursor     <= '0;
            r_holdCnt    <= '0;
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
            r_alarmCnt   <= '0;
            oRun         <= 1'b0;
            oClear       <= 1'b0;
            oField_Up    <= '0;
            oField_Down  <= '0;
            oSel         <= '0;
            oBlink       <= 1'b0;
            oEnd         <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_cursor     <= w_nextCursor;
            r_holdCnt    <= w_holdCntNext;
            r_blinkCnt   <= w_blinkCntNext;
            r_blinkPhase <= w_blinkPhaseNext;
            r_alarmCnt   <= w_alarmCntNext;
            oRun         <= (w_nextState == c_RUN);
            oClear       <= w_clear;
            oField_Up    <= w_up ? (c_ONE << r_cursor) : '0;
            oField_Down  <= w_dn ? (c_ONE << r_cursor) : '0;
            oSel         <= (w_nextState == c_SET) ? (c_ONE << w_nextCursor) : '0;
            oBlink       <= (w_nextState == c_SET) ? w_blinkPhaseNext : 1'b1;
            oEnd         <= (w_nextState == c_END);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl_gen
// Purpose  : Directed self-checking bench for timer_ctrl_gen. Two instances
//            share stimulus: dut (WRAP=1) and dutS (WRAP=0, saturating).
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl_gen;

    logic iClk = 1'b0;
    logic iRst_n = 1'b0;
    logic iTick = 0, iTimer = 0, iSet = 0, iEnd = 0, iZero = 0;
    logic iBtn_U = 0, iBtn_D = 0, iBtn_L = 0, iBtn_R = 0;
    logic iHold_U = 0, iHold_D = 0;

    logic       oRun, oClear, oBlink, oEnd;
    logic [2:0] oField_Up, oField_Down, oSel;
    logic       sRun, sClear, sBlink, sEnd;
    logic [2:0] sField_Up, sField_Down, sSel;

    int total = 0;
    int bad   = 0;

    always #5 iClk = ~iClk;

    timer_ctrl_gen #(
        .NUM_FIELDS(3), .WRAP(1), .REPEAT_DLY(500), .REPEAT_RATE(100),
        .BLINK_HALF(250), .ALARM_TICKS(10)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iTimer(iTimer),
        .iSet(iSet), .iEnd(iEnd), .iZero(iZero),
        .iBtn_U(iBtn_U), .iBtn_D(iBtn_D), .iBtn_L(iBtn_L), .iBtn_R(iBtn_R),
        .iHold_U(iHold_U), .iHold_D(iHold_D),
        .oRun(oRun), .oClear(oClear), .oField_Up(oField_Up),
        .oField_Down(oField_Down), .oSel(oSel), .oBlink(oBlink), .oEnd(oEnd)
    );

    timer_ctrl_gen #(
        .NUM_FIELDS(3), .WRAP(0), .REPEAT_DLY(500), .REPEAT_RATE(100),
        .BLINK_HALF(250), .ALARM_TICKS(10)
    ) dutS (
        .iClk(iClk), .iRst_n(iRst_n), .iTick(iTick), .iTimer(iTimer),
        .iSet(iSet), .iEnd(iEnd), .iZero(iZero),
        .iBtn_U(iBtn_U), .iBtn_D(iBtn_D), .iBtn_L(iBtn_L), .iBtn_R(iBtn_R),
        .iHold_U(iHold_U), .iHold_D(iHold_D),
        .oRun(sRun), .oClear(sClear), .oField_Up(sField_Up),
        .oField_Down(sField_Down), .oSel(sSel), .oBlink(sBlink), .oEnd(sEnd)
    );

    // Advance one clock; outputs are settled 1 ns after the edge.
    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic tick();
        iTick = 1'b1;
        cyc();
        iTick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        cyc(); cyc();
        total++;
        if ({oRun, oClear, oField_Up, oField_Down, oSel, oBlink, oEnd} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {oRun, oClear, oField_Up, oField_Down, oSel, oBlink, oEnd});
        end
        iRst_n = 1'b1;
        iTimer = 1'b1;
        cyc();
        total++;
        if ({oRun, oBlink, oEnd} !== 3'b010) begin
            bad++;
            $display("FAIL idle_after_reset: run/blink/end got %b want 010", {oRun, oBlink, oEnd});
        end
    endtask

    task automatic test_run_end();
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0;
        total++;
        if (oRun !== 1'b1) begin
            bad++;
            $display("FAIL start_run: oRun got %b want 1", oRun);
        end
        iBtn_R = 1'b1; iEnd = 1'b1; cyc(); iBtn_R = 1'b0; iEnd = 1'b0;
        total++;
        if ({oRun, oEnd} !== 2'b00) begin
            bad++;
            $display("FAIL stop_beats_end: run/end got %b want 00", {oRun, oEnd});
        end
        cyc();
        total++;
        if (oEnd !== 1'b0) begin
            bad++;
            $display("FAIL end_stays_low: oEnd got %b want 0", oEnd);
        end
    endtask

    task automatic test_clear();
        iBtn_L = 1'b1; cyc(); iBtn_L = 1'b0;
        total++;
        if (oClear !== 1'b1) begin
            bad++;
            $display("FAIL clear_pulse: oClear got %b want 1", oClear);
        end
        cyc();
        total++;
        if (oClear !== 1'b0) begin
            bad++;
            $display("FAIL clear_one_cycle: oClear got %b want 0", oClear);
        end
        iZero = 1'b1;
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0; cyc();
        total++;
        if (oRun !== 1'b0) begin
            bad++;
            $display("FAIL zero_inhibit: oRun got %b want 0", oRun);
        end
        iZero = 1'b0;
        iTimer = 1'b0;
        iBtn_L = 1'b1; cyc(); iBtn_L = 1'b0;
        total++;
        if (oClear !== 1'b0) begin
            bad++;
            $display("FAIL timer_gating: oClear got %b want 0", oClear);
        end
        iTimer = 1'b1;
        cyc();
    endtask

    task automatic test_cursor();
        logic [2:0] expW [4];
        logic [2:0] expS [4];
        expW = '{3'b001, 3'b010, 3'b100, 3'b001};
        expS = '{3'b001, 3'b010, 3'b100, 3'b100};
        iSet = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                iBtn_L = 1'b1; cyc(); iBtn_L = 1'b0;
            end
            total++;
            if (oSel !== expW[i] || sSel !== expS[i]) begin
                bad++;
                $display("FAIL cursor_step%0d: wrap/sat got %b/%b want %b/%b",
                         i, oSel, sSel, expW[i], expS[i]);
            end
        end
        iBtn_L = 1'b1; iBtn_R = 1'b1; cyc(); iBtn_L = 1'b0; iBtn_R = 1'b0;
        total++;
        if (oSel !== 3'b001 || sSel !== 3'b100) begin
            bad++;
            $display("FAIL cursor_lr_both: got %b/%b want 001/100", oSel, sSel);
        end
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0;
        total++;
        if (oSel !== 3'b100 || sSel !== 3'b010) begin
            bad++;
            $display("FAIL cursor_right: got %b/%b want 100/010", oSel, sSel);
        end
    endtask

    task automatic test_repeat();
        int good;
        int stray;
        good  = 0;
        stray = 0;
        iSet = 1'b0; cyc();
        iSet = 1'b1; cyc();
        iBtn_L = 1'b1; cyc(); iBtn_L = 1'b0;
        iBtn_U = 1'b1; iHold_U = 1'b1; cyc(); iBtn_U = 1'b0;
        total++;
        if (oField_Up !== 3'b010) begin
            bad++;
            $display("FAIL up_press: oField_Up got %b want 010", oField_Up);
        end
        for (int t = 1; t <= 800; t++) begin
            iTick = 1'b1; cyc(); iTick = 1'b0;
            if (oField_Up !== 3'b000) begin
                if (oField_Up === 3'b010 && t >= 500 && (t % 100) == 0) good++;
                else stray++;
            end
            if (oField_Down !== 3'b000) stray++;
            cyc();
            if (oField_Up !== 3'b000 || oField_Down !== 3'b000) stray++;
        end
        total++;
        if (good !== 4 || stray !== 0) begin
            bad++;
            $display("FAIL auto_repeat: on-time pulses %0d stray %0d want 4 and 0", good, stray);
        end
        iHold_U = 1'b0; cyc();
        for (int t = 1; t < 250; t++) tick();
        total++;
        if (oBlink !== 1'b1) begin
            bad++;
            $display("FAIL blink_on: oBlink got %b want 1", oBlink);
        end
        tick();
        total++;
        if (oBlink !== 1'b0) begin
            bad++;
            $display("FAIL blink_off: oBlink got %b want 0", oBlink);
        end
    endtask

    task automatic test_set_exit();
        iSet = 1'b0; iBtn_U = 1'b1; cyc(); iBtn_U = 1'b0;
        total++;
        if (oSel !== 3'b000 || oField_Up !== 3'b000 || oBlink !== 1'b1) begin
            bad++;
            $display("FAIL set_exit: sel/up/blink got %b/%b/%b want 000/000/1",
                     oSel, oField_Up, oBlink);
        end
        cyc();
        total++;
        if (oField_Up !== 3'b000) begin
            bad++;
            $display("FAIL set_exit_late: oField_Up got %b want 000", oField_Up);
        end
    endtask

    task automatic test_alarm();
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0;
        iEnd = 1'b1; cyc(); iEnd = 1'b0;
        total++;
        if ({oRun, oEnd} !== 2'b01) begin
            bad++;
            $display("FAIL end_entry: run/end got %b want 01", {oRun, oEnd});
        end
        for (int t = 1; t <= 9; t++) tick();
        total++;
        if (oEnd !== 1'b1) begin
            bad++;
            $display("FAIL alarm_tick9: oEnd got %b want 1", oEnd);
        end
        iTick = 1'b1; cyc(); iTick = 1'b0;
        total++;
        if (oEnd !== 1'b0) begin
            bad++;
            $display("FAIL alarm_tick10: oEnd got %b want 0", oEnd);
        end
        cyc();
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0;
        iEnd = 1'b1; cyc(); iEnd = 1'b0;
        tick(); tick();
        total++;
        if (oEnd !== 1'b1) begin
            bad++;
            $display("FAIL alarm_before_btn: oEnd got %b want 1", oEnd);
        end
        iTick = 1'b1; iBtn_U = 1'b1; cyc(); iTick = 1'b0; iBtn_U = 1'b0;
        total++;
        if ({oEnd, oClear, oRun} !== 3'b000) begin
            bad++;
            $display("FAIL alarm_btn_dismiss: end/clear/run got %b want 000", {oEnd, oClear, oRun});
        end
    endtask

    task automatic test_async_reset();
        iBtn_R = 1'b1; cyc(); iBtn_R = 1'b0;
        #2;
        iRst_n = 1'b0;
        #1;
        total++;
        if ({oRun, oClear, oField_Up, oField_Down, oSel, oBlink, oEnd} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset: got %b want 0",
                     {oRun, oClear, oField_Up, oField_Down, oSel, oBlink, oEnd});
        end
        cyc();
        iRst_n = 1'b1;
        cyc(); cyc();
        total++;
        if ({oRun, oClear, oField_Up, oField_Down, oEnd} !== 9'd0) begin
            bad++;
            $display("FAIL post_reset_quiet: got %b want 0",
                     {oRun, oClear, oField_Up, oField_Down, oEnd});
        end
    endtask

    initial begin
        test_reset();
        test_run_end();
        test_clear();
        test_cursor();
        test_repeat();
        test_set_exit();
        test_alarm();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/timer_ctrl_gen.md
Name: timer_ctrl_gen

Overview:
Parametrised successor to the clock-project timer controller FSM. Sequences idle/run/set/end for a countdown timer with NUM_FIELDS editable fields. Adds wrap-around cursor, hold-to-auto-repeat on Up/Down, a cursor blink strobe, start inhibit at zero and an end-alarm auto-dismiss timeout. It sits between the button debouncers and the timer datapath, and drives the datapath's count-enable, clear and per-field inc/dec strobes.

Parameters:
NUM_FIELDS, 3, number of editable fields (index 0 = least significant, e.g. sec); must be >= 2
WRAP, 1, 1 = cursor wraps at the ends; 0 = cursor saturates
REPEAT_DLY, 500, iTick periods a held Up/Down must last before auto-repeat starts; must be >= 1
REPEAT_RATE, 100, iTick periods between auto-repeat strobes; must be >= 1
BLINK_HALF, 250, iTick periods per blink half-period
ALARM_TICKS, 10000, iTick periods before END self-dismisses; 0 = never

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iTick  in  1  one-cycle timebase strobe (1 kHz)
iTimer  in  1  timer mode selected; when low, all button inputs are ignored
iSet  in  1  set-mode switch level
iEnd  in  1  datapath reached zero while running (one-cycle pulse)
iZero  in  1  datapath count currently all-zero (level)
iBtn_U, iBtn_D, iBtn_L, iBtn_R  in  1 each  debounced one-cycle press pulses
iHold_U, iHold_D  in  1 each  debounced button level
oRun  out  1  count enable
oClear  out  1  one-cycle clear strobe
oField_Up  out  NUM_FIELDS  one-hot increment strobe
oField_Down  out  NUM_FIELDS  one-hot decrement strobe
oSel  out  NUM_FIELDS  one-hot selected field; all-zero outside SET
oBlink  out  1  display-on phase of the selected field
oEnd  out  1  alarm active

Behaviour:
- Reset: clock iClk, asynchronous active-low reset iRst_n.
  - All outputs 0. State IDLE. Cursor 0. All counters 0.
  - Reset asserted mid-operation aborts immediately. No strobe is emitted after reset release until a new button pulse arrives.
- Button gating: every Btn pulse is qualified by iTimer. All outputs are registered, so an output follows its cause by 1 cycle.
- States: IDLE, RUN, SET, END (2-bit encoding).
- IDLE transitions, priority order:
  - iSet & iTimer: go to SET, cursor = 0.
  - else Btn_L: oClear = 1 for exactly 1 cycle; stay in IDLE.
  - else Btn_R & !iZero: go to RUN.
  - Btn_R & iZero: ignored.
- RUN:
  - oRun = 1.
  - Btn_R: go to IDLE. Btn_R wins over a simultaneous iEnd.
  - else iEnd: go to END.
  - iSet is ignored while in RUN.
- SET:
  - !iSet or !iTimer: go to IDLE. This takes priority over any button in the same cycle.
  - Btn_L moves the cursor +1 (more significant); Btn_R moves it -1.
  - At the ends: WRAP=1 wraps (NUM_FIELDS-1 <-> 0); WRAP=0 holds the cursor.
  - L and R together: no move.
  - oSel = one-hot(cursor).
- Up/Down strobes in SET:
  - Btn_U gives a 1-cycle pulse on oField_Up[cursor]. Btn_D does the same on oField_Down.
  - U and D together: neither.
  - Auto-repeat: a single hold counter, counting iTick, is cleared on any Btn_U/Btn_D pulse and whenever neither hold (or both holds) is asserted.
  - When the counter reaches REPEAT_DLY, emit one strobe for the held direction, then reload to REPEAT_DLY-REPEAT_RATE, so a further strobe follows every REPEAT_RATE ticks.
  - A cursor move clears the hold counter.
- Blink:
  - In SET, a tick counter toggles the blink phase every BLINK_HALF ticks.
  - Any cursor move or Up/Down strobe forces the phase to on and restarts the counter.
  - Outside SET, oBlink = 1.
- END:
  - oEnd = 1.
  - Any qualified Btn_U/D/L/R goes to IDLE.
  - If ALARM_TICKS != 0, the alarm counter counts iTick from END entry; at ALARM_TICKS it goes to IDLE.
  - No oClear is emitted on exit.
- Counter widths: $clog2 of each bound + 1. No overflow is possible.
- Illegal state encoding: go to IDLE.

Test Plan:
- Reset, iTimer=1, iZero=0, Btn_R -> oRun=1 one cycle later. Btn_R and iEnd in the same cycle -> IDLE, oEnd stays 0.
- IDLE with Btn_L -> oClear high for exactly 1 cycle. Btn_R with iZero=1 -> oRun stays 0.
- NUM_FIELDS=3, WRAP=1: iSet=1, then Btn_L x3 -> oSel sequence 001, 010, 100, 001. WRAP=0 -> oSel sequence 001, 010, 100, 100.
- SET, cursor=1, iHold_U held 800 ticks with REPEAT_DLY=500, REPEAT_RATE=100 -> oField_Up=010 pulses at press, tick 500, 600, 700, 800 (5 pulses).
- RUN then iEnd -> oEnd=1. No button, ALARM_TICKS=10 -> IDLE after the 10th iTick. Repeat with Btn_U at tick 3 -> IDLE at tick 3.
- SET, drop iSet while pressing Btn_U in the same cycle -> IDLE, no oField_Up pulse. Pulse iRst_n low mid-RUN -> all outputs 0 asynchronously.
